// File: rtl/wb_stage.sv
// wb_stage -- MEM/WB pipeline register and write-back stage.
//
// The MEM-stage instruction is captured into the MEM/WB register. The
// register-file write port is then driven from that register with no
// further latency. Load data arrives from a synchronous data memory in
// the same cycle the load sits in WB. It is byte/half selected and sign-
// or zero-extended here. The stage also counts retired instructions.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hold the MEM/WB register
//   flush             turn the incoming instruction into a bubble
//   mem_*             MEM-stage instruction fields
//   dmem_rdata        synchronous data-memory read word (valid in WB)
//   wb_valid, wb_rd,
//   wb_reg_write,
//   wb_data           register-file write port / forwarding source
//   instret           retired-instruction counter (wraps)
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [1:0]       mem_result_src,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_write,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret
);

    typedef struct packed {
        logic            reg_write;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_plus4;
        logic [1:0]      result_src;
        logic [2:0]      funct3;
    } memwb_t;

    memwb_t           r;
    logic             valid;
    logic             held;
    logic [XLEN-1:0]  hold;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            valid     <= 1'b0;
            held      <= 1'b0;
            hold      <= '0;
            instret_q <= '0;
        end else begin
            // Flush wins over stall; data fields are don't-care on a bubble.
            if (flush)
                valid <= 1'b0;
            else if (!stall)
                valid <= mem_valid;

            if (!stall) begin
                r.reg_write  <= mem_reg_write;
                r.rd         <= mem_rd;
                r.alu_result <= mem_alu_result;
                r.pc_plus4   <= mem_pc_plus4;
                r.result_src <= mem_result_src;
                r.funct3     <= mem_funct3;
            end

            // The memory word is only guaranteed for one cycle. Freeze it
            // on the first stalled edge so a long stall keeps the
            // original value.
            if (flush || !stall)
                held <= 1'b0;
            else if (valid && !held) begin
                held <= 1'b1;
                hold <= dmem_rdata;
            end

            if (valid && !stall)
                instret_q <= instret_q + 1'b1;
        end
    end

    // Load alignment and extension
    logic [XLEN-1:0] rdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign rdata   = held ? hold : dmem_rdata;
    assign ld_byte = rdata[{r.alu_result[1:0], 3'b000} +: 8];
    assign ld_half = rdata[{r.alu_result[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = rdata;
        case (r.funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

    always_comb begin
        wb_data = r.alu_result;
        case (r.result_src)
            2'b01:   wb_data = ld_data;
            2'b10:   wb_data = r.pc_plus4;
            default: wb_data = r.alu_result;
        endcase
    end

    assign wb_valid     = valid;
    assign wb_rd        = r.rd;
    assign wb_reg_write = valid & r.reg_write & (r.rd != 5'd0);
    assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, flush, mem_valid, mem_reg_write;
    logic [XLEN-1:0]  mem_alu_result, mem_pc_plus4, dmem_rdata;
    logic [4:0]       mem_rd;
    logic [1:0]       mem_result_src;
    logic [2:0]       mem_funct3;
    logic             wb_valid, wb_reg_write;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] instret;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_v   = 1'b0;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_result_src(mem_result_src),
        .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] src, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] pc4);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_src = src;
        mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc4;
    endtask

    // One rising edge; the expected retire count tracks the edge's inputs.
    task automatic tick();
        if (exp_v && !stall) exp_cnt = exp_cnt + 1'b1;
        if (flush) exp_v = 1'b0;
        else if (!stall) exp_v = mem_valid;
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into WB, then present its load word and check data.
    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        set_mem(1'b1, 1'b1, 5'd7, 2'b01, f3, addr, 32'h0);
        tick();
        dmem_rdata = rdata;
        #1;
        chk(tag, wb_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h0;
        set_mem(1'b1, 1'b1, 5'd9, 2'b10, 3'b000, 32'hFFFF_FFFF, 32'h1234_5678);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_we",    {31'b0, wb_reg_write}, 32'h0);
        chk("rst_rd",    {27'b0, wb_rd}, 32'h0);
        chk("rst_data",  wb_data, 32'h0);
        chk("rst_cnt",   {24'b0, instret}, 32'h0);
        #2 rst_n = 1'b1;

        load_chk("lb_b3",  3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
        chk("lb_valid", {31'b0, wb_valid}, 32'h1);
        chk("lb_rd",    {27'b0, wb_rd}, 32'd7);
        chk("lb_we",    {31'b0, wb_reg_write}, 32'h1);
        load_chk("lbu_b3", 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);
        load_chk("lb_b1",  3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);
        load_chk("lh_h1",  3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
        load_chk("lhu_h1", 3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
        load_chk("lh_h0",  3'b001, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);
        load_chk("lw",     3'b010, 32'h0000_2000, 32'h8001_7FFF, 32'h8001_7FFF);
        chk("cnt_loads", {24'b0, instret}, {24'b0, exp_cnt});

        set_mem(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h1234_5678, 32'h0);
        tick(); chk("alu_00", wb_data, 32'h1234_5678);
        set_mem(1'b1, 1'b1, 5'd3, 2'b11, 3'b000, 32'hCAFE_F00D, 32'h0);
        tick(); chk("alu_11", wb_data, 32'hCAFE_F00D);
        set_mem(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0FFF, 32'h0000_0104);
        tick(); chk("jal_pc4", wb_data, 32'h0000_0104);

        // rd=0 never writes, but still retires
        set_mem(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h5, 32'h0);
        tick();
        chk("rd0_we",    {31'b0, wb_reg_write}, 32'h0);
        chk("rd0_valid", {31'b0, wb_valid}, 32'h1);
        set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        tick();
        chk("rd0_cnt", {24'b0, instret}, {24'b0, exp_cnt});
        chk("bubble_valid", {31'b0, wb_valid}, 32'h0);

        // Load stalled three cycles; memory word changes after the first
        set_mem(1'b1, 1'b1, 5'd4, 2'b01, 3'b010, 32'h0000_3000, 32'h0);
        tick();
        dmem_rdata = 32'h1122_3344;
        stall = 1'b1;
        set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        tick();
        dmem_rdata = 32'hDEAD_BEEF; #1;
        chk("stall1_data", wb_data, 32'h1122_3344);
        tick(); chk("stall2_data", wb_data, 32'h1122_3344);
        tick(); chk("stall3_data", wb_data, 32'h1122_3344);
        chk("stall_cnt_hold", {24'b0, instret}, {24'b0, exp_cnt});
        chk("stall_rd", {27'b0, wb_rd}, 32'd4);
        stall = 1'b0;
        tick();
        chk("stall_retire_once", {24'b0, instret}, {24'b0, exp_cnt});
        chk("stall_release_valid", {31'b0, wb_valid}, 32'h0);

        // Flush beats stall
        set_mem(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h77, 32'h0);
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_stall_valid", {31'b0, wb_valid}, 32'h0);
        chk("flush_stall_we", {31'b0, wb_reg_write}, 32'h0);
        stall = 1'b0; flush = 1'b0;
        set_mem(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h78, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_only_valid", {31'b0, wb_valid}, 32'h0);
        chk("flush_cnt", {24'b0, instret}, {24'b0, exp_cnt});

        // Drive the counter to all-ones, then retire once more to wrap
        set_mem(1'b1, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 300 && exp_cnt != 8'hFF; i++) tick();
        set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        chk("cnt_allones", {24'b0, instret}, 32'h0000_00FF);
        tick();
        chk("cnt_wrap", {24'b0, instret}, 32'h0);

        // Async reset between edges during a stalled load
        set_mem(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 32'h0000_4000, 32'h0);
        tick();
        dmem_rdata = 32'hAAAA_5555;
        stall = 1'b1;
        tick();
        dmem_rdata = 32'h1357_9BDF;
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = '0; exp_v = 1'b0;
        chk("arst_valid", {31'b0, wb_valid}, 32'h0);
        chk("arst_we",    {31'b0, wb_reg_write}, 32'h0);
        chk("arst_rd",    {27'b0, wb_rd}, 32'h0);
        chk("arst_data",  wb_data, 32'h0);
        chk("arst_cnt",   {24'b0, instret}, 32'h0);
        #1 rst_n = 1'b1;
        stall = 1'b0;
        set_mem(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 32'h0000_4000, 32'h0);
        tick();
        dmem_rdata = 32'h2468_ACE0; #1;
        chk("post_rst_data", wb_data, 32'h2468_ACE0);
        chk("post_rst_valid", {31'b0, wb_valid}, 32'h1);
        set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
        tick();
        chk("post_rst_cnt", {24'b0, instret}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 64, retire-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  hold MEM/WB register contents.
REQ-006 SHALL have port flush  in  1  replace the incoming instruction with a bubble.
REQ-007 SHALL have port mem_valid  in  1  MEM-stage slot holds a real instruction.
REQ-008 SHALL have port mem_alu_result  in  XLEN  ALU result / load address.
REQ-009 SHALL have port mem_pc_plus4  in  XLEN  link value for JAL/JALR.
REQ-010 SHALL have port mem_rd  in  5  destination register index.
REQ-011 SHALL have port mem_reg_write  in  1  instruction writes rd.
REQ-012 SHALL have port mem_result_src  in  2  00 ALU, 01 load, 10 pc+4, 11 ALU.
REQ-013 SHALL have port mem_funct3  in  3  load size/sign (LB/LH/LW/LBU/LHU encodings).
REQ-014 SHALL have port dmem_rdata  in  XLEN  synchronous data-memory read word, valid the cycle after the access was in MEM.
REQ-015 SHALL have port wb_valid  out  1  WB slot holds a real instruction.
REQ-016 SHALL have port wb_rd  out  5  register-file write index.
REQ-017 SHALL have port wb_reg_write  out  1  register-file write enable.
REQ-018 SHALL have port wb_data  out  XLEN  register-file write data (also forwarding source).
REQ-019 SHALL have port instret  out  CNT_W  retired-instruction count.

Function
REQ-020 SHALL, on a clock edge with stall=0, load all mem_* fields into the MEM/WB register; valid <= mem_valid & ~flush.
REQ-021 SHALL, with stall=1 and flush=0, hold every field unchanged.
REQ-022 SHALL give flush priority over stall: flush=1 clears valid on the edge regardless of stall; data fields are don't-care.
REQ-023 SHALL drive wb_reg_write = valid & reg_write & (rd != 0), combinationally from the register.
REQ-024 SHALL drive wb_valid = valid and wb_rd = registered rd.
REQ-025 SHALL select the load byte by alu_result[1:0] (lane 0..3) and the halfword by alu_result[1] (lower/upper).
REQ-026 SHALL extend loads: 000 sign-extend byte, 001 sign-extend half, 010 full word, 100 zero-extend byte, 101 zero-extend half; other codes pass the full word.
REQ-027 SHALL mux wb_data by result_src: ALU result, extended load, pc_plus4; 11 selects ALU result.
REQ-028 SHALL set a held flag and capture dmem_rdata into a hold register on the first stalled cycle of a valid instruction.
REQ-029 SHALL use the hold register instead of dmem_rdata while held=1.
REQ-030 SHALL clear held whenever the register advances (stall=0) or flush=1.
REQ-031 SHALL increment instret by 1 on every edge where valid=1 and stall=0, regardless of reg_write.
REQ-032 SHALL wrap instret from all-ones to 0 with no saturation or flag.
REQ-033 SHALL produce zero-cycle latency from register contents to wb_* outputs; MEM-to-WB latency is exactly one edge.

Reset
REQ-034 SHALL, while rst_n=0, immediately clear valid, reg_write, rd, alu_result, pc_plus4, result_src, funct3, held, hold register and instret to 0.
REQ-035 SHALL drive wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, instret=0 during reset.
REQ-036 SHALL, on reset assertion mid-stall, discard any held data; the first post-reset edge behaves as REQ-020.

Verification
REQ-037 SHALL cover LB at addr 0x...03 with dmem_rdata=0x80FF_1234 -> wb_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-038 SHALL cover LH at addr 0x...02 with rdata=0x8001_7FFF -> 0xFFFF_8001; LHU at the same address -> 0x0000_8001; LW -> 0x8001_7FFF.
REQ-039 SHALL cover a load stalled 3 cycles with dmem_rdata changing to 0xDEAD_BEEF after the first stall cycle -> wb_data stays the first-cycle value, and instret increments exactly once.
REQ-040 SHALL cover reg_write=1 with rd=0 -> wb_reg_write=0 while instret still increments; flush=1 with stall=1 -> wb_valid=0 next edge.
REQ-041 SHALL cover JAL with result_src=10 and pc_plus4=0x0000_0104 -> wb_data=0x0000_0104; instret preloaded to all-ones -> wraps to 0 on retire.
REQ-042 SHALL cover rst_n asserted asynchronously between edges during a stalled load -> all outputs 0 immediately, held cleared.
